// File: rtl/dsadc_pkg.sv
// dsadc_pkg: shared types, constants and helpers for the dual-slope ADC controller.
//   state_t  : controller phase encoding
//   BBM_CYC  : break-before-make gap length in cycles
//   ch_w()   : width of a channel index for a given channel count (never below 1)
package dsadc_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ZERO  = 3'd1,
      S_BBM   = 3'd2,
      S_INTEG = 3'd3,
      S_DEINT = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int BBM_CYC = 1;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/dual_slope_ctrl_if.sv
// dual_slope_ctrl_if: control/result bundle between the ADC controller and its user.
//   master : drives iniciar, ch_sel, Vint_z; observes switches, status and result
//   slave  : the controller side (receives start and comparator, drives the rest)
//   iniciar   start request          ch_sel    channel to convert
//   Vint_z    integrator comparator  sw_vm     one-hot input switches
//   sw_ref    reference switch       sw_zr     zeroing switch
//   busy      conversion running     done      one-cycle result strobe
//   resultado de-integrate count     ch_out    channel of resultado
//   overflow  conversion saturated
interface dual_slope_ctrl_if #(
   parameter int CNT_W = 10,
   parameter int N_CH  = 4
);
   import dsadc_pkg::*;

   localparam int CH_W = ch_w(N_CH);

   logic             iniciar;
   logic [CH_W-1:0]  ch_sel;
   logic             Vint_z;
   logic [N_CH-1:0]  sw_vm;
   logic             sw_ref;
   logic             sw_zr;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] resultado;
   logic [CH_W-1:0]  ch_out;
   logic             overflow;

   modport master (
      output iniciar, ch_sel, Vint_z,
      input  sw_vm, sw_ref, sw_zr, busy, done, resultado, ch_out, overflow
   );

   modport slave (
      input  iniciar, ch_sel, Vint_z,
      output sw_vm, sw_ref, sw_zr, busy, done, resultado, ch_out, overflow
   );
endinterface

// File: rtl/dual_slope_ctrl_sync.sv
// dsadc_sync: two-flop synchroniser for the asynchronous integrator comparator.
//   clk      system clock
//   reset_n  asynchronous active-low reset, clears both stages
//   i_d      asynchronous input
//   o_q      synchronised output (two cycles of latency)
module dsadc_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end

   assign o_q = r_q;
endmodule

// File: rtl/dual_slope_ctrl.sv
// dual_slope_ctrl: dual-slope ADC sequencer (auto-zero, integrate, de-integrate).
//   clk      system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      dual_slope_ctrl_if.slave: start/channel/comparator in, switches/status/result out
// Build option: define DSADC_AUTOSCAN_EN to convert channels ch_sel..N_CH-1 on one start;
// without it each start converts only ch_sel.
module dual_slope_ctrl
   import dsadc_pkg::*;
#(
   parameter int CNT_W  = 10,
   parameter int N_CH   = 4,
   parameter int AZ_CYC = 16
) (
   input logic              clk,
   input logic              reset_n,
   dual_slope_ctrl_if.slave bus
);
   localparam int CH_W = ch_w(N_CH);
   localparam int AZ_W = $clog2(((AZ_CYC > BBM_CYC) ? AZ_CYC : BBM_CYC) + 1);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_ZERO  = S_ZERO;
   localparam logic [2:0] ST_BBM   = S_BBM;
   localparam logic [2:0] ST_INTEG = S_INTEG;
   localparam logic [2:0] ST_DEINT = S_DEINT;
   localparam logic [2:0] ST_DONE  = S_DONE;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [AZ_W-1:0]  AZ_LAST  = AZ_W'(AZ_CYC - 1);
   localparam logic [AZ_W-1:0]  BBM_LAST = AZ_W'(BBM_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

   logic [2:0]       r_state,    w_state;
   logic [AZ_W-1:0]  r_az,       w_az;
   logic [CNT_W-1:0] r_cnt,      w_cnt;
   logic [CH_W-1:0]  r_ch,       w_ch;
   logic             r_to_deint, w_to_deint;
   logic [CNT_W-1:0] r_res,      w_res;
   logic             r_ovf,      w_ovf;
   logic [CH_W-1:0]  r_ch_out,   w_ch_out;
   logic [N_CH-1:0]  r_sw_vm;
   logic             r_sw_ref;
   logic             r_sw_zr;
   logic             r_busy;
   logic             r_done;
   logic             w_vint;
   logic             w_start;

   dsadc_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (bus.Vint_z),
      .o_q     (w_vint)
   );

   // Out-of-range channels are dropped here, so IDLE never sees them.
   assign w_start = bus.iniciar && (bus.ch_sel <= CH_LAST);

   // r_az times both the auto-zero phase and the break-before-make gap;
   // r_to_deint records which switching phase the current gap leads into.
   always_comb begin
      w_state    = r_state;
      w_az       = r_az;
      w_cnt      = r_cnt;
      w_ch       = r_ch;
      w_to_deint = r_to_deint;
      w_res      = r_res;
      w_ovf      = r_ovf;
      w_ch_out   = r_ch_out;
      case (r_state)
         ST_IDLE:
            if (w_start) begin
               w_state = ST_ZERO;
               w_ch    = bus.ch_sel;
               w_az    = '0;
            end
         ST_ZERO:
            if (r_az == AZ_LAST) begin
               w_state    = ST_BBM;
               w_az       = '0;
               w_to_deint = 1'b0;
            end else begin
               w_az = r_az + AZ_W'(1);
            end
         ST_BBM:
            if (r_az == BBM_LAST) begin
               w_state = r_to_deint ? ST_DEINT : ST_INTEG;
               w_az    = '0;
               w_cnt   = '0;
            end else begin
               w_az = r_az + AZ_W'(1);
            end
         ST_INTEG: begin
            // Full 2^CNT_W cycles: the counter wraps back to 0 on the last one.
            w_cnt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_MAX) begin
               w_state    = ST_BBM;
               w_to_deint = 1'b1;
            end
         end
         ST_DEINT:
            // The comparator is tested first so a crossing on the saturating
            // cycle still reports a valid, non-overflowed count.
            if (w_vint) begin
               w_state  = ST_DONE;
               w_res    = r_cnt;
               w_ovf    = 1'b0;
               w_ch_out = r_ch;
            end else if (r_cnt == CNT_MAX) begin
               w_state  = ST_DONE;
               w_res    = CNT_MAX;
               w_ovf    = 1'b1;
               w_ch_out = r_ch;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         ST_DONE:
`ifdef DSADC_AUTOSCAN_EN
            if (r_ch != CH_LAST) begin
               w_state = ST_ZERO;
               w_ch    = r_ch + CH_W'(1);
               w_az    = '0;
            end else begin
               w_state = ST_IDLE;
            end
`else
            w_state = ST_IDLE;
`endif
         default:
            w_state = ST_IDLE;
      endcase
   end

   // Switch and status outputs are decoded from the next state and registered,
   // so they change on the same edge as the state itself.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_az       <= '0;
         r_cnt      <= '0;
         r_ch       <= '0;
         r_to_deint <= 1'b0;
         r_res      <= '0;
         r_ovf      <= 1'b0;
         r_ch_out   <= '0;
         r_sw_vm    <= '0;
         r_sw_ref   <= 1'b0;
         r_sw_zr    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_az       <= w_az;
         r_cnt      <= w_cnt;
         r_ch       <= w_ch;
         r_to_deint <= w_to_deint;
         r_res      <= w_res;
         r_ovf      <= w_ovf;
         r_ch_out   <= w_ch_out;
         r_sw_vm    <= (w_state == ST_INTEG) ? (N_CH'(1) << w_ch) : '0;
         r_sw_ref   <= (w_state == ST_DEINT);
         r_sw_zr    <= (w_state == ST_IDLE) || (w_state == ST_ZERO) || (w_state == ST_DONE);
         r_busy     <= (w_state != ST_IDLE);
         r_done     <= (w_state == ST_DONE);
      end

   assign bus.sw_vm     = r_sw_vm;
   assign bus.sw_ref    = r_sw_ref;
   assign bus.sw_zr     = r_sw_zr;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.resultado = r_res;
   assign bus.ch_out    = r_ch_out;
   assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_dual_slope_ctrl.sv
// tb_dual_slope_ctrl: scoreboard bench for dual_slope_ctrl (CNT_W=4, N_CH=4, AZ_CYC=3),
// plus a N_CH=3 instance for the out-of-range channel case.
module tb_dual_slope_ctrl;
   localparam int CNT_W = 4;
   localparam int N_CH  = 4;
   localparam int AZ    = 3;
   localparam int MAXV  = (1 << CNT_W) - 1;
   localparam int NEVER = 1000;

   typedef struct {
      int ch;
      int res;
      int ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   int   plan_q[$];

   always #5 clk = ~clk;

   dual_slope_ctrl_if #(.CNT_W(CNT_W), .N_CH(N_CH)) bus ();
   dual_slope_ctrl_if #(.CNT_W(CNT_W), .N_CH(3))    bus3 ();

   dual_slope_ctrl #(.CNT_W(CNT_W), .N_CH(N_CH), .AZ_CYC(AZ)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   dual_slope_ctrl #(.CNT_W(CNT_W), .N_CH(3), .AZ_CYC(AZ)) u_dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Comparator raised during DEINT cycle t is seen two cycles later; the count
   // then equals that cycle index, or the conversion saturates at full scale.
   function automatic exp_t model(input int ch, input int t);
      exp_t e;
      int   k;
      k     = t + 2;
      e.ch  = ch;
      e.res = (k <= MAXV) ? k : MAXV;
      e.ovf = (k > MAXV) ? 1 : 0;
      return e;
   endfunction

   task automatic push_plan(input int ch, input int t);
`ifdef DSADC_AUTOSCAN_EN
      for (int c = ch; c < N_CH; c++) begin
         int tt;
         tt = (c == ch) ? t : int'($urandom_range(0, 18));
         plan_q.push_back(tt);
         exp_q.push_back(model(c, tt));
      end
`else
      plan_q.push_back(t);
      exp_q.push_back(model(ch, t));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.busy || exp_q.size() != 0) && n < 1000) begin
         step();
         n++;
      end
      chk("conversion_timeout", 32'(n < 1000), 1);
      if (n >= 1000) begin
         exp_q.delete();
         plan_q.delete();
      end
   endtask

   task automatic run_conv(input int ch, input int t, input bit poke);
      int n;
      wait_idle();
      push_plan(ch, t);
      bus.iniciar = 1'b1;
      bus.ch_sel  = 2'(ch);
      step();
      bus.iniciar = 1'b0;
      if (poke) begin
         n = 0;
         while (bus.sw_vm == '0 && n < 100) begin
            step();
            n++;
         end
         repeat (3) step();
         bus.iniciar = 1'b1;
         bus.ch_sel  = 2'($urandom_range(0, 3));
         step();
         bus.iniciar = 1'b0;
      end
      wait_idle();
   endtask

   // Comparator driver: noise everywhere it must be ignored, then the planned
   // crossing inside DEINT; kept low across the gap before DEINT.
   initial begin
      int k, kv, plan;
      k = 0;
      kv = 0;
      plan = NEVER;
      bus.Vint_z = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.sw_ref) begin
            if (k == 0) plan = (plan_q.size() != 0) ? plan_q.pop_front() : NEVER;
            if (k == plan) bus.Vint_z = 1'b1;
            k++;
         end else begin
            k  = 0;
            kv = (bus.sw_vm != '0) ? kv + 1 : 0;
            bus.Vint_z = (kv >= 10 || (bus.busy && !bus.sw_zr && bus.sw_vm == '0)) ? 1'b0
                         : 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: switch rules every cycle, phase lengths, and scoreboard on done.
   initial begin
      int   ph, prev_ph, zr_run, vm_run;
      bit   busy_chk, busy_exp;
      exp_t e;
      prev_ph = 1;
      zr_run = 0;
      vm_run = 0;
      busy_chk = 1'b0;
      busy_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_ph = 1;
            zr_run = 0;
            vm_run = 0;
            busy_chk = 1'b0;
         end else begin
            ph = bus.sw_zr ? 1 : (bus.sw_vm != '0) ? 2 : bus.sw_ref ? 3 : 0;
            chk("switch_exclusive", 32'($countones({bus.sw_vm, bus.sw_ref, bus.sw_zr}) <= 1), 1);
            if (ph != prev_ph && (ph == 2 || ph == 3)) chk("bbm_before_phase", prev_ph, 0);
            if (ph == 0) chk("bbm_single_cycle", 32'(prev_ph != 0), 1);
            if (ph == 1 && bus.busy && !bus.done) zr_run++;
            if (ph == 0 && prev_ph == 1) begin
               chk("zero_len", zr_run, AZ);
               zr_run = 0;
            end
            if (ph == 2) begin
               vm_run++;
               chk("vm_channel", 32'(bus.sw_vm),
                   (exp_q.size() != 0) ? 32'(1 << exp_q[0].ch) : 32'hFFFF_FFFF);
            end
            if (ph != 2 && prev_ph == 2) begin
               chk("integ_len", vm_run, 1 << CNT_W);
               vm_run = 0;
            end
            if (busy_chk) begin
               chk("busy_after_done", 32'(bus.busy), 32'(busy_exp));
               chk("done_width", 32'(bus.done), 0);
               busy_chk = 1'b0;
            end
            if (bus.done) begin
               chk("done_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("ch_out", 32'(bus.ch_out), e.ch);
                  chk("resultado", 32'(bus.resultado), e.res);
                  chk("overflow", 32'(bus.overflow), e.ovf);
               end
               chk("busy_at_done", 32'(bus.busy), 1);
               busy_chk = 1'b1;
               busy_exp = (exp_q.size() != 0);
            end
            prev_ph = ph;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sw_zr"}, 32'(bus.sw_zr), 1);
      chk({tag, "_sw_vm"}, 32'(bus.sw_vm), 0);
      chk({tag, "_sw_ref"}, 32'(bus.sw_ref), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_resultado"}, 32'(bus.resultado), 0);
      chk({tag, "_ch_out"}, 32'(bus.ch_out), 0);
      chk({tag, "_overflow"}, 32'(bus.overflow), 0);
   endtask

   initial begin
      int n;
      bus.iniciar  = 1'b0;
      bus.ch_sel   = '0;
      bus3.iniciar = 1'b0;
      bus3.ch_sel  = '0;
      bus3.Vint_z  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");

      // Three-channel instance: channel 3 is out of range and must be ignored.
      step();
      reset_n      = 1'b1;
      bus3.iniciar = 1'b1;
      bus3.ch_sel  = 2'd3;
      step();
      bus3.iniciar = 1'b0;
      repeat (2) begin
         chk("bad_ch_busy", 32'(bus3.busy), 0);
         chk("bad_ch_sw_zr", 32'(bus3.sw_zr), 1);
         chk("bad_ch_sw_vm", 32'(bus3.sw_vm), 0);
         step();
      end
      bus3.iniciar = 1'b1;
      bus3.ch_sel  = 2'd2;
      step();
      bus3.iniciar = 1'b0;
      chk("good_ch_busy", 32'(bus3.busy), 1);

      // Directed cases: nominal, never crossing, crossing on saturation,
      // crossing just too late, earliest crossing, start ignored mid-INTEG.
      run_conv(2, 5, 1'b0);
      run_conv(0, NEVER, 1'b0);
      run_conv(1, 13, 1'b0);
      run_conv(3, 14, 1'b1);
      run_conv(0, 0, 1'b0);
      repeat (12) run_conv($urandom_range(0, 3), $urandom_range(0, 18), 1'($urandom_range(0, 1)));

      // Reset in the middle of DEINT, then an immediate restart.
      wait_idle();
      push_plan(1, NEVER);
      bus.iniciar = 1'b1;
      bus.ch_sel  = 2'd1;
      step();
      bus.iniciar = 1'b0;
      n = 0;
      while (!bus.sw_ref && n < 100) begin
         step();
         n++;
      end
      chk("reach_deint", 32'(bus.sw_ref), 1);
      repeat (5) step();
      reset_n = 1'b0;
      exp_q.delete();
      plan_q.delete();
      @(negedge clk);
      chk_reset_vals("mid_reset");
      step();
      reset_n = 1'b1;
      push_plan(2, 4);
      bus.iniciar = 1'b1;
      bus.ch_sel  = 2'd2;
      step();
      bus.iniciar = 1'b0;
      chk("start_after_reset", 32'(bus.busy), 1);
      wait_idle();

      repeat (5) step();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
